// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch stage.
// Holds the bus widths and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int INST_BUS     = 32;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles four little-endian bytes from the
// memory controller into one instruction, then holds it until decode accepts it.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MEM_ADDR_BUS-1:0] pc_i,
  input  logic                    br,
  input  logic                    id_stall,
  output logic                    mem_req,
  output logic [MEM_ADDR_BUS-1:0] mem_addr,
  input  logic                    mem_ready,
  input  logic [7:0]              mem_data,
  output logic [MEM_ADDR_BUS-1:0] pc_next,
  output logic                    stall_req,
  output logic                    if_valid,
  output logic [INST_BUS-1:0]     if_inst,
  output logic [MEM_ADDR_BUS-1:0] if_pc
);

  fetch_state_e            state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    if_valid_q, if_valid_d;
  logic [INST_BUS-1:0]     if_inst_q, if_inst_d;
  logic [MEM_ADDR_BUS-1:0] if_pc_q, if_pc_d;

  // Request stays up during reset too; the returned byte is simply dropped.
  always_comb begin
    mem_req   = (state_q == ST_FETCH);
    mem_addr  = pc_i + {{(MEM_ADDR_BUS-2){1'b0}}, cnt_q};
    pc_next   = pc_i + 32'd4;
    stall_req = !((state_q == ST_HOLD) && !id_stall);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    // A branch wins over everything, including a byte landing this edge.
    if (br) begin
      state_d    = ST_FETCH;
      cnt_d      = 2'd0;
      if_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            if_inst_d[{cnt_q, 3'b000} +: 8] = mem_data;
            if (cnt_q == 2'd3) begin
              state_d    = ST_HOLD;
              if_valid_d = 1'b1;
              if_pc_d    = pc_i;
              cnt_d      = 2'd0;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            state_d    = ST_FETCH;
            cnt_d      = 2'd0;
            if_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_FETCH;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      cnt_q      <= 2'd0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have no parameters; bus widths come from shared defines (MemAddrBus = 32 bits, InstBus = 32 bits).
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc_i  in  32  current PC from the PC register.
REQ-005 br  in  1  branch/flush request from downstream; same signal drives the PC register.
REQ-006 id_stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-007 mem_req  out  1  byte read request to the memory controller.
REQ-008 mem_addr  out  32  byte address of the request.
REQ-009 mem_ready  in  1  the controller accepts the request and mem_data is valid this cycle.
REQ-010 mem_data  in  8  returned byte.
REQ-011 pc_next  out  32  pc_i + 4, fed to the PC register's next-PC input.
REQ-012 stall_req  out  1  holds the PC register; drives its stall input.
REQ-013 if_valid  out  1  if_inst/if_pc hold a complete instruction.
REQ-014 if_inst  out  32  assembled instruction, little-endian.
REQ-015 if_pc  out  32  address of if_inst.

Function
REQ-016 States: FETCH (byte counter cnt 0..3) and HOLD.
REQ-017 In FETCH: mem_req = 1 and mem_addr = pc_i + cnt, modulo 2^32.
REQ-018 Byte acceptance: a byte SHALL be accepted on an edge where mem_req and mem_ready are both 1.
REQ-019 Byte placement: on acceptance, mem_data SHALL be written to if_inst bits [8*cnt+7 : 8*cnt].
REQ-020 Bytes 0-2: acceptance SHALL increment cnt.
REQ-021 Byte 3: acceptance SHALL set if_valid = 1, set if_pc = pc_i and move to HOLD.
REQ-022 No mem_ready: while mem_ready = 0, cnt and the partial instruction SHALL hold.
REQ-023 In HOLD: mem_req = 0, and if_inst, if_pc and if_valid SHALL stay stable while id_stall = 1.
REQ-024 stall_req = NOT (state == HOLD AND id_stall == 0), combinationally.
REQ-025 Handoff from HOLD: an edge in HOLD with id_stall = 0 SHALL hand off the instruction and return to FETCH with cnt = 0. if_valid clears unless a new instruction completes, which it cannot in the same edge. The PC register advances on the same edge.
REQ-026 Latency: minimum 5 cycles per instruction (4 accepted bytes + 1 HOLD cycle).
REQ-027 pc_next = pc_i + 4, combinational, wrapping at 2^32.
REQ-028 Branch: br = 1 on an edge SHALL move the block to FETCH with cnt = 0 and if_valid = 0, from any state.
REQ-029 Branch discard: a byte accepted on the same edge as br SHALL be discarded.
REQ-030 Branch priority: br SHALL take priority over id_stall and over completion of byte 3.
REQ-031 Post-branch fetch: fetch restarts at the branch target on the cycle after br.
REQ-032 Misalignment: misaligned pc_i SHALL be fetched byte-wise without error.

Reset
REQ-033 Reset SHALL put the block in FETCH with cnt = 0, if_valid = 0, if_inst = 0 and if_pc = 0.
REQ-034 Reset SHALL take priority over br and any in-flight byte.
REQ-035 During reset: mem_req SHALL still follow REQ-017; the byte is discarded.

Structure
REQ-036 State encodings, MemAddrBus and InstBus SHALL live in the shared define file.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 Basic fetch: reset, pc_i = 0x00000000, mem_ready = 1, bytes 0x13,0x05,0x10,0x00 -> mem_addr 0,1,2,3; at the 4th edge if_valid = 1, if_inst = 0x00100513, if_pc = 0.
REQ-039 Handoff timing: stall_req = 1 for the four FETCH cycles and 0 in the HOLD cycle.
REQ-040 Memory wait: mem_ready low for 3 cycles before byte 2 -> mem_addr holds pc_i+2; assembled instruction unchanged; completion delayed 3 cycles.
REQ-041 Decode stall: id_stall = 1 for 4 cycles in HOLD -> if_inst/if_pc/if_valid stable, stall_req = 1, mem_req = 0; handoff on the first cycle with id_stall = 0.
REQ-042 Flush: br = 1 during cnt = 2 (byte accepted same edge) -> next cycle cnt = 0, if_valid = 0, mem_addr = new pc_i. br in HOLD with id_stall = 0 -> no handoff, if_valid = 0.
REQ-043 Wrap-around: pc_i = 0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; pc_next = 0x00000002.
REQ-044 Mid-fetch reset: assert reset at cnt = 3 -> outputs return to reset values; fetch restarts at cnt = 0.
